// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin 4:1 mux arbiter into a one-entry registered output stage; define MUX_ARB_GRANT_CNT_EN for per-lane grant counters.
// Latency 1 cycle from input handshake to out_valid; all in_ready drop while the output is stalled (out_valid & !out_ready).
module mux_4_1_rr_arbiter #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_sel,
  input  logic                out_ready
`ifdef MUX_ARB_GRANT_CNT_EN
  ,
  output logic [4*CNT_W-1:0]  grant_cnt
`endif
);

  logic [1:0]        rr_ptr;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic              accept;
  logic              any_req;
  logic              xfer;
  logic [DATA_W-1:0] sel_word;

  assign accept  = !out_valid || out_ready;
  assign any_req = |in_valid;
  assign xfer    = accept && any_req;

  // Scan offsets from farthest to nearest so the lane closest to rr_ptr wins.
  always_comb begin
    win = rr_ptr;
    idx = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (in_valid[idx]) win = idx;
    end
  end

  assign in_ready = xfer ? (4'b0001 << win) : 4'b0000;
  assign sel_word = in_data[win*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      rr_ptr    <= 2'd0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_word;
      out_sel   <= win;
      rr_ptr    <= win + 2'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[i] <= '0;
      end else if (xfer && (win == 2'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
    assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule
